// File: rtl/mat_mul_loader.sv
// Streams two MAT_SIZE x MAT_SIZE matrices row by row into the A/B BRAMs, then
// hands off to the matmul core and waits for its completion.
module mat_mul_loader #(
   parameter int DWIDTH   = 16,
   parameter int AWIDTH   = 7,
   parameter int MAT_SIZE = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_go,
   input  logic                         i_s_valid,
   input  logic [DWIDTH-1:0]            i_s_data,
   output logic                         o_s_ready,
   output logic                         o_enable_writing_to_mem,
   output logic [AWIDTH-1:0]            o_addr_pi,
   output logic [MAT_SIZE*DWIDTH-1:0]   o_data_pi,
   output logic                         o_we_a,
   output logic                         o_we_b,
   output logic                         o_start_mat_mul,
   input  logic                         i_done_mat_mul,
   output logic                         o_busy,
   output logic                         o_complete
);

   localparam int CW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;

   typedef enum logic [2:0] {IDLE, FILL, SETTLE, WRITE, RUN, FINISH} state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic [AWIDTH-1:0]            r_row;
   logic [CW-1:0]                r_col;
   logic                         r_mat_b;
   logic                         r_settle;
   logic [MAT_SIZE*DWIDTH-1:0]   r_data;

   logic w_accept;
   logic w_last_col;
   logic w_last_row;

   assign w_accept   = i_s_valid && (r_state == FILL);
   assign w_last_col = (r_col == CW'(MAT_SIZE - 1));
   assign w_last_row = (r_row == AWIDTH'(MAT_SIZE - 1));

   assign o_addr_pi  = r_row;
   assign o_data_pi  = r_data;
   assign o_busy     = (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next                  = r_state;
      o_s_ready               = 1'b0;
      o_enable_writing_to_mem = 1'b0;
      o_we_a                  = 1'b0;
      o_we_b                  = 1'b0;
      o_start_mat_mul         = 1'b0;
      o_complete              = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_go) w_next = FILL;
         end
         FILL: begin
            o_s_ready               = 1'b1;
            o_enable_writing_to_mem = 1'b1;
            if (w_accept && w_last_col) w_next = SETTLE;
         end
         SETTLE: begin
            // two cycles so the BRAM-side address pipeline has caught up
            o_enable_writing_to_mem = 1'b1;
            if (r_settle) w_next = WRITE;
         end
         WRITE: begin
            o_enable_writing_to_mem = 1'b1;
            o_we_a                  = !r_mat_b;
            o_we_b                  = r_mat_b;
            w_next                  = (w_last_row && r_mat_b) ? RUN : FILL;
         end
         RUN: begin
            o_start_mat_mul = 1'b1;
            if (i_done_mat_mul) w_next = FINISH;
         end
         FINISH: begin
            o_complete = 1'b1;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_row    <= '0;
         r_col    <= '0;
         r_mat_b  <= 1'b0;
         r_settle <= 1'b0;
         r_data   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_go) begin
                  r_row   <= '0;
                  r_col   <= '0;
                  r_mat_b <= 1'b0;
               end
            end
            FILL: begin
               r_settle <= 1'b0;
               if (w_accept) begin
                  r_data[r_col*DWIDTH +: DWIDTH] <= i_s_data;
                  r_col <= w_last_col ? '0 : r_col + CW'(1);
               end
            end
            SETTLE: r_settle <= 1'b1;
            WRITE: begin
               if (!w_last_row) begin
                  r_row <= r_row + AWIDTH'(1);
               end else if (!r_mat_b) begin
                  r_row   <= '0;
                  r_mat_b <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mul_loader.sv
// Randomized bench for mat_mul_loader: expected BRAM row writes are queued when a
// load is launched and matched by a monitor against every write strobe.
module tb_mat_mul_loader;

   localparam int DW = 16;
   localparam int AW = 7;
   localparam int MS = 32;
   localparam int NEL = 2 * MS * MS;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 i_go = 1'b0;
   logic                 i_s_valid = 1'b0;
   logic [DW-1:0]        i_s_data = '0;
   logic                 i_done_mat_mul = 1'b0;
   logic                 o_s_ready, o_enable_writing_to_mem, o_we_a, o_we_b;
   logic                 o_start_mat_mul, o_busy, o_complete;
   logic [AW-1:0]        o_addr_pi;
   logic [MS*DW-1:0]     o_data_pi;

   mat_mul_loader #(.DWIDTH(DW), .AWIDTH(AW), .MAT_SIZE(MS)) dut (
      .clk(clk), .reset(reset), .i_go(i_go), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
      .o_s_ready(o_s_ready), .o_enable_writing_to_mem(o_enable_writing_to_mem),
      .o_addr_pi(o_addr_pi), .o_data_pi(o_data_pi), .o_we_a(o_we_a), .o_we_b(o_we_b),
      .o_start_mat_mul(o_start_mat_mul), .i_done_mat_mul(i_done_mat_mul),
      .o_busy(o_busy), .o_complete(o_complete)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             is_a;
      logic [AW-1:0]    addr;
      logic [MS*DW-1:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: matrix m, row r, column k holds stream index m*MS*MS + r*MS + k.
   task automatic push_expected();
      wr_t e;
      for (int m = 0; m < 2; m++) begin
         for (int r = 0; r < MS; r++) begin
            e.is_a = (m == 0);
            e.addr = AW'(r);
            for (int k = 0; k < MS; k++) e.data[k*DW +: DW] = DW'(m*MS*MS + r*MS + k);
            sb.push_back(e);
         end
      end
   endtask

   // Monitor: pops the scoreboard on each strobe and checks per-row timing.
   logic [AW-1:0] h_addr1, h_addr2;
   logic          h_en1, h_en2, h_strobe1;
   int            acc_age;

   always @(negedge clk) begin
      if (reset) begin
         h_addr1 = '0; h_addr2 = '0; h_en1 = 1'b0; h_en2 = 1'b0; h_strobe1 = 1'b0;
         acc_age = 100;
      end else begin
         acc_age++;
         chk(!(o_we_a && o_we_b), "both_strobes", {o_we_a, o_we_b}, 0);
         if (o_s_ready) chk(o_enable_writing_to_mem && !o_start_mat_mul, "ready_outside_fill",
                            {o_enable_writing_to_mem, o_start_mat_mul}, 2);
         if (o_we_a || o_we_b) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_strobe", o_addr_pi, 0);
            end else begin
               wr_t e;
               e = sb.pop_front();
               chk(o_we_a == e.is_a && o_we_b == !e.is_a, "strobe_sel", {o_we_a, o_we_b}, {e.is_a, !e.is_a});
               chk(o_addr_pi == e.addr, "addr_pi", o_addr_pi, e.addr);
               n_checks++;
               if (o_data_pi !== e.data) begin
                  n_errors++;
                  $display("FAIL data_pi row %0d: got %h expected %h", e.addr, o_data_pi, e.data);
               end
            end
            chk(h_addr1 == o_addr_pi && h_addr2 == o_addr_pi, "addr_settle", {h_addr2, h_addr1}, {o_addr_pi, o_addr_pi});
            chk(o_enable_writing_to_mem && h_en1 && h_en2, "enable_at_strobe", {o_enable_writing_to_mem, h_en1, h_en2}, 7);
            chk(!h_strobe1, "strobe_width", h_strobe1, 0);
            chk(acc_age == 3, "row_latency", acc_age, 3);
         end
         if (i_s_valid && o_s_ready) acc_age = 0;
         h_addr2 = h_addr1; h_addr1 = o_addr_pi;
         h_en2 = h_en1; h_en1 = o_enable_writing_to_mem;
         h_strobe1 = o_we_a || o_we_b;
      end
   end

   task automatic check_all_zero(input string name);
      chk({o_s_ready, o_enable_writing_to_mem, o_we_a, o_we_b, o_start_mat_mul, o_busy, o_complete} == 7'd0,
          name, {o_s_ready, o_enable_writing_to_mem, o_we_a, o_we_b, o_start_mat_mul, o_busy, o_complete}, 0);
      chk(o_addr_pi == '0, {name, "_addr"}, o_addr_pi, 0);
      chk(o_data_pi == '0, {name, "_data"}, o_data_pi[63:0], 0);
   endtask

   // Launch a load and stream elements until stop_at have been accepted.
   task automatic run_load(input int pct, input int stop_at, input bit noise);
      int idx = 0;
      int budget = 0;
      @(negedge clk);
      i_go = 1'b1;
      while (idx < stop_at && budget < 20000) begin
         @(negedge clk);
         budget++;
         i_go = 1'b0;
         i_done_mat_mul = 1'b0;
         if (noise && o_s_ready && $urandom_range(99) < 3) i_go = 1'b1;
         if (noise && o_s_ready && $urandom_range(99) < 3) i_done_mat_mul = 1'b1;
         i_s_valid = ($urandom_range(99) < pct);
         i_s_data  = i_s_valid ? DW'(idx) : DW'($urandom);
         if (i_s_valid && o_s_ready) idx++;
      end
      chk(idx == stop_at, "stream_budget", idx, stop_at);
      @(negedge clk);
      i_s_valid = 1'b0;
      i_go = 1'b0;
      i_done_mat_mul = 1'b0;
   endtask

   task automatic finish_run(input bit noise);
      int budget = 0;
      while (!o_start_mat_mul && budget < 400) begin
         @(negedge clk);
         budget++;
      end
      chk(o_start_mat_mul, "start_timeout", o_start_mat_mul, 1);
      chk(!o_enable_writing_to_mem && o_busy, "run_outputs", {o_enable_writing_to_mem, o_busy}, 1);
      chk(sb.size() == 0, "writes_remaining", sb.size(), 0);
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         i_go = noise && (c % 97 == 5);
      end
      i_go = 1'b0;
      chk(o_start_mat_mul && !o_complete, "run_hold", {o_start_mat_mul, o_complete}, 2);
      i_done_mat_mul = 1'b1;
      @(negedge clk);
      i_done_mat_mul = 1'b0;
      chk(!o_start_mat_mul && o_complete && o_busy, "finish_state", {o_start_mat_mul, o_complete, o_busy}, 3);
      @(negedge clk);
      chk(!o_complete && !o_busy, "back_idle", {o_complete, o_busy}, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("idle_after_reset");

      push_expected();
      run_load(100, NEL, 1'b0);
      finish_run(1'b0);

      push_expected();
      run_load(50, NEL, 1'b1);
      finish_run(1'b1);

      push_expected();
      run_load(100, MS + 40, 1'b0);
      reset = 1'b1;
      i_go = 1'b1;
      i_done_mat_mul = 1'b1;
      @(negedge clk);
      i_go = 1'b0;
      i_done_mat_mul = 1'b0;
      check_all_zero("mid_reset");
      sb.delete();
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("after_mid_reset");

      push_expected();
      run_load(100, NEL, 1'b0);
      finish_run(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
